// File: rtl/reg_multi_seq_if.sv
// Memory request bus between the register block-transfer sequencer
// and a word-addressed memory with a ready/complete handshake.
interface reg_multi_seq_if;
    logic [15:0] Mem_Addr;
    logic [15:0] Mem_WData;
    logic [15:0] Mem_RData;
    logic        Mem_Read;
    logic        Mem_Write;
    logic        Mem_Ready;

    modport master (
        output Mem_Addr,
        output Mem_WData,
        output Mem_Read,
        output Mem_Write,
        input  Mem_RData,
        input  Mem_Ready
    );

    modport slave (
        input  Mem_Addr,
        input  Mem_WData,
        input  Mem_Read,
        input  Mem_Write,
        output Mem_RData,
        output Mem_Ready
    );
endinterface

// File: rtl/reg_multi_seq.sv
// Multi-register load/store sequencer: moves Count consecutive registers
// to or from consecutive memory words, one request at a time.
module reg_multi_seq #(
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Mode,
    input  logic [3:0]  Base_Reg,
    input  logic [4:0]  Count,
    input  logic [15:0] Base_Addr,
    output logic [3:0]  Read_Register1,
    input  logic [15:0] Read_Data1,
    output logic [3:0]  Write_Reg,
    output logic [15:0] Write_Data,
    output logic        RegWrite,
    output logic        Busy,
    output logic        Done,
    reg_multi_seq_if.master mem
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        FIN
    } state_t;

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    state_t      state;
    state_t      state_nxt;
    logic        mode_q;
    logic [3:0]  cur_reg;
    logic [15:0] cur_addr;
    logic [4:0]  remaining;
    logic [15:0] hold;

    logic [4:0]  cnt_clamp;
    logic        last;
    logic        advance;
    logic        load_done;

    assign cnt_clamp = (Count > 5'd16) ? 5'd16 : Count;
    assign last      = (remaining == 5'd1);
    assign load_done = (state == XFER) && mode_q && mem.Mem_Ready;
    // A store advances on memory completion; a load only after its write-back.
    assign advance   = ((state == XFER) && !mode_q && mem.Mem_Ready)
                     || (state == WB);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mode_q    <= 1'b0;
            cur_reg   <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            hold      <= '0;
        end else begin
            if ((state == IDLE) && Start) begin
                mode_q    <= Mode;
                cur_reg   <= Base_Reg;
                cur_addr  <= Base_Addr;
                remaining <= cnt_clamp;
            end
            if (load_done) begin
                hold <= mem.Mem_RData;
            end
            if (advance) begin
                cur_reg   <= cur_reg + 4'd1;
                cur_addr  <= cur_addr + STEP;
                remaining <= remaining - 5'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = (cnt_clamp == 5'd0) ? FIN : XFER;
                end
            end
            XFER: begin
                if (mem.Mem_Ready) begin
                    if (mode_q) begin
                        state_nxt = WB;
                    end else begin
                        state_nxt = last ? FIN : XFER;
                    end
                end
            end
            WB: begin
                state_nxt = last ? FIN : XFER;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        Read_Register1 = '0;
        Write_Reg      = '0;
        Write_Data     = '0;
        RegWrite       = 1'b0;
        Busy           = (state != IDLE);
        Done           = 1'b0;
        mem.Mem_Addr   = '0;
        mem.Mem_WData  = '0;
        mem.Mem_Read   = 1'b0;
        mem.Mem_Write  = 1'b0;
        unique case (state)
            XFER: begin
                mem.Mem_Addr = cur_addr;
                if (mode_q) begin
                    mem.Mem_Read = 1'b1;
                end else begin
                    Read_Register1 = cur_reg;
                    mem.Mem_WData  = Read_Data1;
                    mem.Mem_Write  = 1'b1;
                end
            end
            WB: begin
                Write_Reg  = cur_reg;
                Write_Data = hold;
                RegWrite   = 1'b1;
            end
            FIN: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
